// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Turns a raw, asynchronous, bouncing pushbutton or switch into a clean level
// in the clk domain. It also produces one-cycle rise/fall strobes that line
// up with every change of that level.
//
// The raw input first passes through a two-flop synchronizer (btn -> s1 -> s2).
// A four-state FSM then watches s2. `level` changes only after STABLE_CYCLES
// consecutive s2 samples have differed from it. Any sample that agrees with
// the current level restarts qualification from zero. The delay from a settled
// btn change to the change of `level` is 2 + STABLE_CYCLES rising edges.
//
// Parameters:
//   STABLE_CYCLES  consecutive differing samples needed to flip `level`
//                  (legal range 2 .. 2**CNT_W-1)
//   CNT_W          width of the stability counter
//
// Ports:
//   clk     system clock; all state changes on its rising edge
//   rst_n   asynchronous, active-low reset
//   btn     raw asynchronous button/switch input
//   level   debounced level (registered)
//   rise    one-cycle pulse coincident with level going 0->1 (registered)
//   fall    one-cycle pulse coincident with level going 1->0 (registered)
//   toggle  only with BUTTON_DEBOUNCER_TOGGLE_EN defined: flips on every
//           rise, giving push-on/push-off behaviour (registered)
//
// Optional feature macro: BUTTON_DEBOUNCER_TOGGLE_EN
// ---------------------------------------------------------------------------
module button_debouncer #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    ,
    output logic toggle
`endif
);

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } state_t;

    // Terminal count: reaching it on a differing sample means that sample is
    // the STABLE_CYCLES-th in a row, so the commit happens on this edge.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s1;
    logic             s2;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    logic             rise_next;
    logic             fall_next;

    // Two-flop synchronizer. s2 is the only form of btn that the FSM sees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // State, counter and output registers. The outputs come from next-state
    // decode, so they change on the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

    // Next-state logic. The first differing sample already counts as 1, and
    // one sample that agrees with the level drops back to IDLE. This holds
    // even on the cycle that would have committed.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            IDLE_LO: begin
                if (s2) begin
                    state_next = WAIT_HI;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            WAIT_HI: begin
                if (!s2) begin
                    state_next = IDLE_LO;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE_HI;
                    cnt_next   = '0;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (!s2) begin
                    state_next = WAIT_LO;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            WAIT_LO: begin
                if (s2) begin
                    state_next = IDLE_HI;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = IDLE_LO;
                    cnt_next   = '0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE_LO;
                cnt_next   = '0;
            end
        endcase
        level_next = (state_next == IDLE_HI) || (state_next == WAIT_LO);
    end

`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    // Push-on/push-off: flips on the same edge that rise goes high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle <= 1'b0;
        end else if (rise_next) begin
            toggle <= ~toggle;
        end
    end
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//
// Self-checking bench for button_debouncer with STABLE_CYCLES=4, CNT_W=3.
//
// Each stimulus step drives btn for one clock. It pushes the expected
// {level, rise, fall, toggle} onto a scoreboard queue, then pops and compares
// that entry just after the clock edge.
//
// The expectation model works only from the btn history that the bench drove.
// btn reaches the FSM two edges later. The level flips once STABLE_CYCLES
// consecutive delayed samples have differed from it.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic btn;
    logic level;
    logic rise;
    logic fall;
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
    logic toggle;
`endif

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
        logic toggle;
    } exp_t;

    exp_t expQ[$];
    logic histQ[$];
    logic mLevel;
    logic mTog;
    int   mRun;

    int compared   = 0;
    int mismatched = 0;
    int stepIdx;
    int riseCount;
    int fallCount;
    int lastRiseStep;
    int lastFallStep;

    always #5 clk = ~clk;

    button_debouncer #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .level (level),
        .rise  (rise),
        .fall  (fall)
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
        ,
        .toggle(toggle)
`endif
    );

    // Single-bit comparison point.
    task automatic checkBit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Integer comparison point, used for strobe timing and counts.
    task automatic checkInt(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clearStats();
        stepIdx      = 0;
        riseCount    = 0;
        fallCount    = 0;
        lastRiseStep = -1;
        lastFallStep = -1;
    endtask

    // Model state after reset: the synchronizer holds two zero samples.
    task automatic modelReset();
        histQ  = '{1'b0, 1'b0};
        mLevel = 1'b0;
        mRun   = 0;
        mTog   = 1'b0;
    endtask

    // All outputs must read 0 while reset is asserted.
    task automatic checkReset(input string tag);
        checkBit({tag, "_level"}, level, 1'b0);
        checkBit({tag, "_rise"},  rise,  1'b0);
        checkBit({tag, "_fall"},  fall,  1'b0);
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
        checkBit({tag, "_toggle"}, toggle, 1'b0);
`endif
    endtask

    // Pop one scoreboard entry and compare it with the DUT outputs.
    task automatic checkOutput(input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s_queue: observed empty scoreboard expected one entry", tag);
        end else begin
            e = expQ.pop_front();
            checkBit({tag, "_level"}, level, e.level);
            checkBit({tag, "_rise"},  rise,  e.rise);
            checkBit({tag, "_fall"},  fall,  e.fall);
`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
            checkBit({tag, "_toggle"}, toggle, e.toggle);
`endif
        end
        if (rise === 1'b1) begin
            riseCount++;
            lastRiseStep = stepIdx;
        end
        if (fall === 1'b1) begin
            fallCount++;
            lastFallStep = stepIdx;
        end
    endtask

    // Drive btn for one clock. The expected result of that edge goes onto
    // the scoreboard, and it is checked 1 ns after the edge.
    task automatic applyStimulus(input logic b, input string tag);
        exp_t e;
        logic sample;
        btn = b;
        histQ.push_back(b);
        sample = histQ.pop_front();
        e = '0;
        if (sample != mLevel) begin
            mRun++;
            if (mRun == STABLE_CYCLES) begin
                mLevel = sample;
                mRun   = 0;
                e.rise = sample;
                e.fall = ~sample;
                if (sample) mTog = ~mTog;
            end
        end else begin
            mRun = 0;
        end
        e.level  = mLevel;
        e.toggle = mTog;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        stepIdx++;
        checkOutput(tag);
    endtask

    task automatic applyRun(input logic b, input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(b, tag);
    endtask

    initial begin
        logic bouncePat [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Power-on reset held across two edges.
        rst_n = 1'b0;
        btn   = 1'b0;
        clearStats();
        repeat (2) @(posedge clk);
        #1;
        checkReset("por");
        modelReset();
        rst_n = 1'b1;
        applyRun(1'b0, 5, "idle");

        // Test 1: go partway into WAIT_HI, then assert reset between edges
        // with btn=1. Keep btn at 1 through release. Rise is due on edge 6.
        applyRun(1'b1, 3, "t1_pre");
        #3;
        rst_n = 1'b0;
        #1;
        checkReset("t1_async");
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clearStats();
        applyRun(1'b1, 7, "t1");
        checkInt("t1_rise_edge", lastRiseStep, 6);
        checkInt("t1_rise_count", riseCount, 1);

        // Test 2: release the button, then make a clean press held 20 cycles.
        applyRun(1'b0, 10, "t2_pre");
        clearStats();
        applyRun(1'b1, 20, "t2");
        checkInt("t2_rise_edge", lastRiseStep, 6);
        checkInt("t2_rise_count", riseCount, 1);
        checkInt("t2_fall_count", fallCount, 0);

        // Test 3: a 3-cycle glitch on a released button must be rejected.
        applyRun(1'b0, 10, "t3_pre");
        clearStats();
        applyRun(1'b1, 3, "t3_glitch");
        applyRun(1'b0, 10, "t3_settle");
        checkInt("t3_rise_count", riseCount, 0);
        checkInt("t3_fall_count", fallCount, 0);
        checkInt("t3_cnt", int'(dut.cnt), 0);

        // Test 4: a bouncing press. The last 0->1 is at step 6, so the single
        // rise is due at step 11.
        clearStats();
        for (int i = 0; i < 10; i++) applyStimulus(bouncePat[i], "t4_bounce");
        applyRun(1'b1, 6, "t4_hold");
        checkInt("t4_rise_edge", lastRiseStep, 11);
        checkInt("t4_rise_count", riseCount, 1);
        checkInt("t4_fall_count", fallCount, 0);

        // Test 5: release from level=1. Fall is due on edge 6.
        clearStats();
        applyRun(1'b0, 12, "t5");
        checkInt("t5_fall_edge", lastFallStep, 6);
        checkInt("t5_fall_count", fallCount, 1);
        checkInt("t5_rise_count", riseCount, 0);

        // Test 6: reset while in WAIT_HI with cnt=2. No rise may follow.
        clearStats();
        applyRun(1'b1, 4, "t6_pre");
        checkInt("t6_cnt_before", int'(dut.cnt), 2);
        #3;
        rst_n = 1'b0;
        #1;
        checkReset("t6_async");
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clearStats();
        applyRun(1'b0, 12, "t6_post");
        checkInt("t6_rise_count", riseCount, 0);
        checkInt("t6_cnt_after", int'(dut.cnt), 0);

`ifdef BUTTON_DEBOUNCER_TOGGLE_EN
        // Three clean presses make toggle step through 1, 0, 1.
        for (int p = 0; p < 3; p++) begin
            clearStats();
            applyRun(1'b1, 8, "tog_press");
            checkInt("tog_rise_edge", lastRiseStep, 6);
            checkBit("tog_value", toggle, (p % 2 == 0) ? 1'b1 : 1'b0);
            applyRun(1'b0, 8, "tog_release");
        end
`endif

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
